// File: rtl/muldiv_pkg.sv
// Shared types for the EX-stage multiply/divide unit: opcodes, FSM states
// and the magnitude helper used when preparing signed operands.
package muldiv_pkg;

    typedef enum logic [3:0] {
        NOP   = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MFHI  = 4'd5,
        MFLO  = 4'd6,
        MTHI  = 4'd7,
        MTLO  = 4'd8
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    localparam int MAX_W = 64;

    // Callers sign-extend into MAX_W bits, so the magnitude of the most
    // negative WIDTH-bit value still fits when truncated back to WIDTH.
    function automatic logic [MAX_W-1:0] abs_val(input logic signed [MAX_W-1:0] x);
        return x[MAX_W-1] ? -x : x;
    endfunction

endpackage

// File: rtl/muldiv_hilo_unit_iter_core.sv
// Iterative datapath: shift-add multiply (BITS_PER_CYCLE multiplier bits per
// step) and restoring divide (one quotient bit per step) on unsigned magnitudes.
module muldiv_iter_core #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_mul,
    input  logic                 start_div,
    input  logic                 step_mul,
    input  logic                 step_div,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   acc,
    output logic                 last
);

    localparam int N_MUL = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   opb;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] partial;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;

    always_comb begin
        partial = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (opb[k]) partial = partial + (mcand << k);
        end
    end

    // For divide, acc holds {remainder, dividend/quotient}; the remainder is
    // always below the divisor, so one extra bit covers the trial subtract.
    assign shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign diff    = shifted - {1'b0, opb};
    assign last    = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            mcand <= '0;
            opb   <= '0;
            cnt   <= '0;
        end else if (start_mul) begin
            acc   <= '0;
            mcand <= {{WIDTH{1'b0}}, a};
            opb   <= b;
            cnt   <= CW'(N_MUL - 1);
        end else if (start_div) begin
            acc   <= {{WIDTH{1'b0}}, a};
            opb   <= b;
            cnt   <= CW'(WIDTH - 1);
        end else if (step_mul) begin
            acc   <= acc + partial;
            mcand <= mcand << BITS_PER_CYCLE;
            opb   <= opb >> BITS_PER_CYCLE;
            cnt   <= cnt - CW'(1);
        end else if (step_div) begin
            if (!diff[WIDTH]) acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else              acc <= {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// EX-stage multiply/divide unit with architectural HI/LO, MTHI/MTLO/MFHI/MFLO,
// abort from the pipeline flush, and a stall request to the hazard logic.
module muldiv_hilo_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             abort,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             state;
    logic               accept, known_op, is_mul_op, is_div_op, is_signed, rt_zero;
    logic               start_mul, start_div, last;
    logic               fix_div, dz_fix, neg_lo, neg_hi;
    logic [WIDTH-1:0]   saved_rs;
    logic [WIDTH-1:0]   rs_mag, rt_mag, op_a, op_b;
    logic [2*WIDTH-1:0] core_acc, prod;
    logic [WIDTH-1:0]   quot, rem;

    assign busy      = (state != ST_IDLE);
    assign known_op  = (op >= 4'd1) && (op <= 4'd8);
    assign stall     = op_valid && busy && known_op;
    assign accept    = op_valid && !busy && !abort;
    assign is_mul_op = (op == MULT) || (op == MULTU);
    assign is_div_op = (op == DIV) || (op == DIVU);
    assign is_signed = (op == MULT) || (op == DIV);
    assign rt_zero   = (rt_val == '0);
    assign start_mul = accept && is_mul_op;
    assign start_div = accept && is_div_op && !rt_zero;

    assign rs_mag = WIDTH'(abs_val(MAX_W'(signed'(rs_val))));
    assign rt_mag = WIDTH'(abs_val(MAX_W'(signed'(rt_val))));
    assign op_a   = is_signed ? rs_mag : rs_val;
    assign op_b   = is_signed ? rt_mag : rt_val;

    muldiv_iter_core #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .start_mul (start_mul),
        .start_div (start_div),
        .step_mul  (state == ST_MUL),
        .step_div  (state == ST_DIV),
        .a         (op_a),
        .b         (op_b),
        .acc       (core_acc),
        .last      (last)
    );

    assign prod = neg_lo ? -core_acc : core_acc;
    assign quot = neg_lo ? -core_acc[WIDTH-1:0] : core_acc[WIDTH-1:0];
    assign rem  = neg_hi ? -core_acc[2*WIDTH-1:WIDTH] : core_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        rd_data = '0;
        if (!busy) begin
            if (op == MFHI)      rd_data = hi;
            else if (op == MFLO) rd_data = lo;
        end
    end

    // HI/LO change only on MTHI/MTLO at accept or at a non-aborted FIX exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            fix_div     <= 1'b0;
            dz_fix      <= 1'b0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            saved_rs    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (op == MTHI)      hi <= rs_val;
                        else if (op == MTLO) lo <= rs_val;
                        if (is_mul_op || is_div_op) begin
                            div_by_zero <= 1'b0;
                            fix_div     <= is_div_op;
                            dz_fix      <= is_div_op && rt_zero;
                            saved_rs    <= rs_val;
                            neg_lo      <= is_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                            neg_hi      <= is_signed && rs_val[WIDTH-1];
                            if (is_mul_op)    state <= ST_MUL;
                            else if (rt_zero) state <= ST_FIX;
                            else              state <= ST_DIV;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (abort)     state <= ST_IDLE;
                    else if (last) state <= ST_FIX;
                end
                ST_FIX: begin
                    state <= ST_IDLE;
                    if (!abort) begin
                        done <= 1'b1;
                        if (dz_fix) begin
                            hi          <= saved_rs;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                        end else if (fix_div) begin
                            hi <= rem;
                            lo <= quot;
                        end else begin
                            {hi, lo} <= prod;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed bench for muldiv_hilo_unit: a radix-2 instance for the main checks
// and a radix-16 instance for the short-latency multiply and MTHI/MFHI path.
module tb_muldiv_hilo_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic [3:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        abort;

    logic        stall, busy, done, div_by_zero;
    logic [31:0] rd_data, hi, lo;
    logic        stall4, busy4, done4, div_by_zero4;
    logic [31:0] rd_data4, hi4, lo4;

    int errors = 0;
    int checks = 0;
    int n;
    int stall_cnt;

    muldiv_hilo_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op          (op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .abort       (abort),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .rd_data     (rd_data),
        .hi          (hi),
        .lo          (lo)
    );

    muldiv_hilo_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op          (op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .abort       (abort),
        .stall       (stall4),
        .busy        (busy4),
        .done        (done4),
        .div_by_zero (div_by_zero4),
        .rd_data     (rd_data4),
        .hi          (hi4),
        .lo          (lo4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one op for a single edge, then returns to NOP.
    task automatic applyStimulus(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        op       = o;
        rs_val   = a;
        rt_val   = b;
        tick();
        op_valid = 1'b0;
        op       = NOP;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        rst      = 1'b1;
        abort    = 1'b0;
        op_valid = 1'b1;
        op       = MTHI;
        rs_val   = 32'h55;
        rt_val   = 32'h0;
        tick();
        tick();
        op_valid = 1'b0;
        op       = NOP;
        #1;
        checkOutput("reset_hi", hi, 32'h0);
        checkOutput("reset_lo", lo, 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_stall", 32'(stall), 32'd0);
        checkOutput("reset_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        tick();

        applyStimulus(MULT, 32'hFFFF_FFFD, 32'd5);
        checkOutput("mult_busy", 32'(busy), 32'd1);
        wait_idle(n);
        checkOutput("mult_latency", 32'(n), 32'd33);
        checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
        checkOutput("mult_lo", lo, 32'hFFFF_FFF1);
        checkOutput("mult_done", 32'(done), 32'd1);

        applyStimulus(DIVU, 32'd100, 32'd7);
        checkOutput("b2b_done_pulse", 32'(done), 32'd0);
        checkOutput("b2b_accepted", 32'(busy), 32'd1);
        wait_idle(n);
        checkOutput("divu_latency", 32'(n), 32'd33);
        checkOutput("divu_lo", lo, 32'd14);
        checkOutput("divu_hi", hi, 32'd2);

        applyStimulus(DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        checkOutput("div_neg_lo", lo, 32'hFFFF_FFFD);
        checkOutput("div_neg_hi", hi, 32'hFFFF_FFFF);

        applyStimulus(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        checkOutput("div_min_lo", lo, 32'h8000_0000);
        checkOutput("div_min_hi", hi, 32'h0);
        checkOutput("div_min_dbz", 32'(div_by_zero), 32'd0);

        applyStimulus(DIV, 32'd5, 32'd0);
        wait_idle(n);
        checkOutput("dbz_latency", 32'(n), 32'd1);
        checkOutput("dbz_hi", hi, 32'd5);
        checkOutput("dbz_lo", lo, 32'hFFFF_FFFF);
        checkOutput("dbz_flag", 32'(div_by_zero), 32'd1);
        checkOutput("dbz_done", 32'(done), 32'd1);
        tick();
        checkOutput("dbz_sticky", 32'(div_by_zero), 32'd1);
        applyStimulus(MULT, 32'd3, 32'd4);
        checkOutput("dbz_cleared", 32'(div_by_zero), 32'd0);
        wait_idle(n);
        checkOutput("mult34_lo", lo, 32'd12);

        applyStimulus(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        op_valid  = 1'b1;
        op        = MFLO;
        stall_cnt = 0;
        n         = 0;
        while (busy && n < 100) begin
            if (stall) stall_cnt++;
            tick();
            n++;
        end
        checkOutput("mflo_stall_cycles", 32'(stall_cnt), 32'd33);
        checkOutput("mflo_rd_data", rd_data, 32'h0000_0001);
        checkOutput("mflo_hi", hi, 32'hFFFF_FFFE);
        checkOutput("mflo_no_stall", 32'(stall), 32'd0);
        checkOutput("mflo_done", 32'(done), 32'd1);
        op_valid = 1'b0;
        op       = NOP;
        tick();

        applyStimulus(MULT, 32'd2, 32'd3);
        op_valid = 1'b1;
        op       = 4'hF;
        #1;
        checkOutput("reserved_no_stall", 32'(stall), 32'd0);
        op       = MTHI;
        rs_val   = 32'hDEAD;
        #1;
        checkOutput("mthi_busy_stall", 32'(stall), 32'd1);
        tick();
        op_valid = 1'b0;
        op       = NOP;
        wait_idle(n);
        checkOutput("mthi_not_taken_hi", hi, 32'h0);
        checkOutput("mult23_lo", lo, 32'd6);

        applyStimulus(MTHI, 32'hA5A5_A5A5, 32'd0);
        applyStimulus(MTLO, 32'hA5A5_A5A5, 32'd0);
        applyStimulus(MULT, 32'd7, 32'd6);
        repeat (9) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_hi", hi, 32'hA5A5_A5A5);
        checkOutput("abort_lo", lo, 32'hA5A5_A5A5);
        tick();
        checkOutput("abort_no_late_done", 32'(done), 32'd0);

        applyStimulus(MULT, 32'd7, 32'd6);
        repeat (32) tick();
        checkOutput("fix_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("fix_abort_done", 32'(done), 32'd0);
        checkOutput("fix_abort_lo", lo, 32'hA5A5_A5A5);

        abort = 1'b1;
        applyStimulus(MTLO, 32'h1234, 32'd0);
        abort = 1'b0;
        checkOutput("idle_abort_lo", lo, 32'hA5A5_A5A5);

        applyStimulus(MULT, 32'd7, 32'd6);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid_hi", hi, 32'h0);
        checkOutput("rst_mid_lo", lo, 32'h0);
        checkOutput("rst_mid_done", 32'(done), 32'd0);
        checkOutput("rst_mid_stall", 32'(stall), 32'd0);
        checkOutput("rst_mid_rd", rd_data, 32'h0);
        tick();

        applyStimulus(MULT, 32'd7, 32'd6);
        repeat (8) tick();
        checkOutput("r16_busy_edge8", 32'(busy4), 32'd1);
        tick();
        checkOutput("r16_idle_edge9", 32'(busy4), 32'd0);
        checkOutput("r16_lo", lo4, 32'd42);
        checkOutput("r16_done", 32'(done4), 32'd1);
        wait_idle(n);
        applyStimulus(MTHI, 32'h1234, 32'd0);
        op_valid = 1'b1;
        op       = MFHI;
        #1;
        checkOutput("r16_mfhi", rd_data4, 32'h1234);
        checkOutput("r16_mfhi_stall", 32'(stall4), 32'd0);
        checkOutput("mfhi", rd_data, 32'h1234);
        tick();
        op_valid = 1'b0;
        op       = NOP;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
